catch_control: RTL

- Sits directly upstream of the collectible box controller.
- Detects player/box overlap and issues the `box_caught` pulse, drives `player_is_holding_box`, and supplies a pseudo-random `y_amplitude_in` for the next arc.
- Tracks delivery of a carried box to a drop zone and keeps the score.
- Advances only on cycles where `game_en` is high.

---
 rtl/catch_control.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/catch_control.sv
// Catch detection, carry/delivery tracking and scoring for the collectible box.
// Feeds box_caught and a pseudo-random spawn amplitude to the box controller.
module catch_control #(
  parameter logic [9:0] DROP_X_MIN     = 10'd20,
  parameter logic [9:0] DROP_X_MAX     = 10'd80,
  parameter logic [7:0] DELIVER_CYCLES = 8'd30,
  parameter logic [9:0] LFSR_SEED      = 10'h1A5,
  parameter int         AMP_BITS       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_en,
  input  logic [9:0]  player_x,
  input  logic [9:0]  player_y,
  input  logic [9:0]  player_w,
  input  logic [9:0]  player_h,
  input  logic [9:0]  box_x_pos,
  input  logic [9:0]  box_y_pos,
  input  logic [9:0]  box_width,
  input  logic [9:0]  box_height,
  input  logic        box_active,
  input  logic        drop_req,
  output logic        box_caught,
  output logic        player_is_holding_box,
  output logic [9:0]  y_amplitude_out,
  output logic        delivered,
  output logic [15:0] score
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_CAUGHT,
    S_HOLD,
    S_DELIVER
  } state_t;

  localparam logic [7:0] DWELL_MAX =
    (DELIVER_CYCLES == 8'd0) ? 8'd1 : DELIVER_CYCLES;

  state_t      state_q, state_d;
  logic        caught_q, caught_d;
  logic        hold_q, hold_d;
  logic        deliv_q, deliv_d;
  logic [15:0] score_q, score_d;
  logic [9:0]  amp_q, amp_d;
  logic [7:0]  dwell_q, dwell_d;
  logic [9:0]  lfsr_q, lfsr_d;

  logic [10:0] box_r, box_b, ply_r, ply_b;
  logic        overlap, in_zone;
  logic [9:0]  amp_new;

  // 11-bit edges so a box near the right border never wraps
  assign box_r = {1'b0, box_x_pos} + {1'b0, box_width};
  assign box_b = {1'b0, box_y_pos} + {1'b0, box_height};
  assign ply_r = {1'b0, player_x} + {1'b0, player_w};
  assign ply_b = {1'b0, player_y} + {1'b0, player_h};

  assign overlap = ({1'b0, player_x} < box_r) &&
                   ({1'b0, box_x_pos} < ply_r) &&
                   ({1'b0, player_y} < box_b) &&
                   ({1'b0, box_y_pos} < ply_b);

  assign in_zone = (player_x >= DROP_X_MIN) &&
                   (player_x <= DROP_X_MAX);

  assign lfsr_d  = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
  assign amp_new = {{(10-AMP_BITS){1'b0}}, lfsr_q[AMP_BITS-1:0]};

  always_comb begin
    state_d  = state_q;
    caught_d = 1'b0;
    deliv_d  = 1'b0;
    hold_d   = hold_q;
    score_d  = score_q;
    amp_d    = amp_q;
    dwell_d  = dwell_q;
    unique case (state_q)
      S_EMPTY: begin
        if (box_active && overlap) begin
          state_d  = S_CAUGHT;
          caught_d = 1'b1;
          hold_d   = 1'b1;
          amp_d    = amp_new;
        end
      end
      S_CAUGHT: state_d = S_HOLD;
      S_HOLD: begin
        if (drop_req) begin
          state_d = S_EMPTY;
          hold_d  = 1'b0;
        end else if (in_zone) begin
          state_d = S_DELIVER;
          dwell_d = 8'd1;
        end
      end
      S_DELIVER: begin
        if (drop_req) begin
          state_d = S_EMPTY;
          hold_d  = 1'b0;
          dwell_d = 8'd0;
        end else if (!in_zone) begin
          state_d = S_HOLD;
          dwell_d = 8'd0;
        end else if (dwell_q == DWELL_MAX) begin
          state_d = S_EMPTY;
          deliv_d = 1'b1;
          hold_d  = 1'b0;
          dwell_d = 8'd0;
          if (score_q != 16'hFFFF)
            score_d = score_q + 16'd1;
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_EMPTY;
      caught_q <= 1'b0;
      hold_q   <= 1'b0;
      deliv_q  <= 1'b0;
      score_q  <= 16'd0;
      amp_q    <= 10'd0;
      dwell_q  <= 8'd0;
      lfsr_q   <= LFSR_SEED;
    end else if (game_en) begin
      state_q  <= state_d;
      caught_q <= caught_d;
      hold_q   <= hold_d;
      deliv_q  <= deliv_d;
      score_q  <= score_d;
      amp_q    <= amp_d;
      dwell_q  <= dwell_d;
      lfsr_q   <= lfsr_d;
    end
  end

  assign box_caught            = caught_q;
  assign player_is_holding_box = hold_q;
  assign y_amplitude_out       = amp_q;
  assign delivered             = deliv_q;
  assign score                 = score_q;

endmodule
